// File: rtl/wb_retire_stage.sv
// Multi-lane write-back/retire stage: precise exception kill across lanes,
// register-file write, and a trace FIFO serialising retired writes onto the debug port.
module wb_retire_stage #(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  ws_allowin,
  input  logic [LANES-1:0]      ms_to_ws_valid,
  input  logic [LANES*32-1:0]   ms_pc,
  input  logic [LANES*32-1:0]   ms_result,
  input  logic [LANES*4-1:0]    ms_gr_we,
  input  logic [LANES*5-1:0]    ms_dest,
  input  logic [LANES-1:0]      ms_exc,
  input  logic [LANES-1:0]      ms_eret,
  output logic [LANES*4-1:0]    rf_we,
  output logic [LANES*5-1:0]    rf_waddr,
  output logic [LANES*32-1:0]   rf_wdata,
  output logic [LANES-1:0]      fwd_valid,
  output logic                  send_flush,
  output logic                  exc_valid,
  output logic                  eret_valid,
  output logic [31:0]           exc_pc,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int POP_W = $clog2(LANES + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  num;
    logic [31:0] data;
  } trace_t;

  logic [LANES-1:0]         ws_valid;
  logic [LANES-1:0]         ws_exc;
  logic [LANES-1:0]         ws_eret;
  logic [LANES-1:0][31:0]   ws_pc;
  logic [LANES-1:0][31:0]   ws_result;
  logic [LANES-1:0][3:0]    ws_gr_we;
  logic [LANES-1:0][4:0]    ws_dest;

  logic                     ws_ready_go;
  logic [LANES-1:0]         eff;
  logic [LANES-1:0]         wr;
  logic [LANES-1:0][POP_W-1:0] off;
  logic [POP_W-1:0]         need;
  logic [POP_W-1:0]         push_n;
  logic                     pop;
  logic                     flush_hit;
  logic                     flush_exc;
  logic                     flush_eret;
  logic [31:0]              flush_pc;
  trace_t                   lane_entry [LANES];
  trace_t                   first_entry;
  trace_t                   head;
  trace_t                   dbg_q;

  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  trace_t                   trace_mem [TRACE_DEPTH];

  // Stage register; flush beats a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ws_valid  <= '0;
      ws_exc    <= '0;
      ws_eret   <= '0;
      ws_pc     <= '0;
      ws_result <= '0;
      ws_gr_we  <= '0;
      ws_dest   <= '0;
    end else begin
      if (flush)           ws_valid <= '0;
      else if (ws_allowin) ws_valid <= ms_to_ws_valid;
      if (ws_allowin && (|ms_to_ws_valid)) begin
        ws_exc    <= ms_exc;
        ws_eret   <= ms_eret;
        ws_pc     <= ms_pc;
        ws_result <= ms_result;
        ws_gr_we  <= ms_gr_we;
        ws_dest   <= ms_dest;
      end
    end
  end

  // Lane decode: the oldest exc/eret kills every younger lane.
  always_comb begin : lane_decode
    logic             killed;
    logic             first_hit;
    logic [POP_W-1:0] acc;
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    killed      = 1'b0;
    first_hit   = 1'b0;
    acc         = '0;
    eff         = '0;
    wr          = '0;
    off         = '0;
    flush_hit   = 1'b0;
    flush_exc   = 1'b0;
    flush_eret  = 1'b0;
    flush_pc    = '0;
    first_entry = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_entry[i] = '{pc: ws_pc[i], we: ws_gr_we[i], num: ws_dest[i], data: ws_result[i]};
      eff[i] = ws_valid[i] && !killed;
      wr[i]  = eff[i] && !ws_exc[i] && (|ws_gr_we[i]);
      off[i] = acc;
      if (wr[i]) begin
        acc = acc + POP_W'(1);
        if (!first_hit) begin
          first_hit   = 1'b1;
          first_entry = lane_entry[i];
        end
      end
      if (eff[i] && (ws_exc[i] || ws_eret[i]) && !flush_hit) begin
        flush_hit  = 1'b1;
        flush_exc  = ws_exc[i];
        flush_eret = !ws_exc[i];
        flush_pc   = ws_pc[i];
      end
      if (ws_valid[i] && (ws_exc[i] || ws_eret[i])) killed = 1'b1;
    end
    need = acc;
  end

  assign ws_ready_go = (CNT_W'(TRACE_DEPTH) - count) >= CNT_W'(need);
  assign ws_allowin  = !(|ws_valid) || ws_ready_go;
  assign fwd_valid   = wr;
  assign rf_waddr    = ws_dest;
  assign rf_wdata    = ws_result;
  assign send_flush  = ws_ready_go && flush_hit;
  assign exc_valid   = send_flush && flush_exc;
  assign eret_valid  = send_flush && flush_eret;
  assign exc_pc      = flush_pc;

  always_comb begin
    rf_we = '0;
    for (int i = 0; i < LANES; i++)
      rf_we[i*4 +: 4] = ws_gr_we[i] & {4{wr[i] && ws_ready_go}};
  end

  // An empty FIFO bypasses the first pushed entry straight to the debug register.
  assign push_n = ws_ready_go ? need : '0;
  assign pop    = (count != '0) || (push_n != '0);
  assign head   = (count != '0) ? trace_mem[rd_ptr] : first_entry;

  // NOTE: the trace storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (ws_ready_go && wr[i]) trace_mem[wr_ptr + PTR_W'(off[i])] <= lane_entry[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dbg_q  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop);
      dbg_q  <= pop ? head : '0;
    end
  end

  assign debug_wb_pc       = dbg_q.pc;
  assign debug_wb_rf_wen   = dbg_q.we;
  assign debug_wb_rf_wnum  = dbg_q.num;
  assign debug_wb_rf_wdata = dbg_q.data;

endmodule

// File: tb/tb_wb_retire_stage.sv
// Self-checking bench for wb_retire_stage: directed scenarios then random traffic,
// compared every cycle against a queue-based retire/trace model.
module tb_wb_retire_stage;

  localparam int LANES = 2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  num;
    logic [31:0] data;
  } entry_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic                ws_allowin;
  logic [LANES-1:0]    ms_to_ws_valid;
  logic [LANES*32-1:0] ms_pc;
  logic [LANES*32-1:0] ms_result;
  logic [LANES*4-1:0]  ms_gr_we;
  logic [LANES*5-1:0]  ms_dest;
  logic [LANES-1:0]    ms_exc;
  logic [LANES-1:0]    ms_eret;
  logic [LANES*4-1:0]  rf_we;
  logic [LANES*5-1:0]  rf_waddr;
  logic [LANES*32-1:0] rf_wdata;
  logic [LANES-1:0]    fwd_valid;
  logic                send_flush;
  logic                exc_valid;
  logic                eret_valid;
  logic [31:0]         exc_pc;
  logic [31:0]         debug_wb_pc;
  logic [3:0]          debug_wb_rf_wen;
  logic [4:0]          debug_wb_rf_wnum;
  logic [31:0]         debug_wb_rf_wdata;

  wb_retire_stage #(.LANES(LANES), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_result(ms_result),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_exc(ms_exc), .ms_eret(ms_eret),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
    .send_flush(send_flush), .exc_valid(exc_valid), .eret_valid(eret_valid), .exc_pc(exc_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  // Reference model: the held bundle plus a queue of trace entries still owed to the sink.
  logic [LANES-1:0] m_valid, m_exc, m_eret;
  logic [31:0]      m_pc  [LANES];
  logic [31:0]      m_res [LANES];
  logic [3:0]       m_we  [LANES];
  logic [4:0]       m_dest[LANES];
  entry_t           q[$];
  entry_t           m_dbg;
  bit               m_allow;
  int               n_checks = 0;
  int               n_fail   = 0;
  int               stall_cycles;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = '0;
    m_exc   = '0;
    m_eret  = '0;
    for (int i = 0; i < LANES; i++) begin
      m_pc[i] = '0; m_res[i] = '0; m_we[i] = '0; m_dest[i] = '0;
    end
    q.delete();
    m_dbg = '0;
  endtask

  task automatic idle_inputs();
    ms_to_ws_valid = '0; ms_pc = '0; ms_result = '0; ms_gr_we = '0;
    ms_dest = '0; ms_exc = '0; ms_eret = '0; flush = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [3:0] we,
                          input logic [4:0] dest, input logic [31:0] res,
                          input bit exc, input bit eret);
    ms_to_ws_valid[i]   = 1'b1;
    ms_pc[i*32 +: 32]   = pc;
    ms_gr_we[i*4 +: 4]  = we;
    ms_dest[i*5 +: 5]   = dest;
    ms_result[i*32 +: 32] = res;
    ms_exc[i]           = exc;
    ms_eret[i]          = eret;
  endtask

  // Check every output against the model, advance the model with the current inputs, clock once.
  task automatic step();
    int                  kp;
    int                  need;
    bit                  ready;
    bit                  send;
    logic [LANES-1:0]    wrs;
    logic [LANES*4-1:0]  e_we;
    logic [LANES*5-1:0]  e_addr;
    logic [LANES*32-1:0] e_data;
    logic                e_exc, e_eret;
    logic [31:0]         e_pc;
    #1;
    kp = LANES;
    for (int i = LANES - 1; i >= 0; i--)
      if (m_valid[i] && (m_exc[i] || m_eret[i])) kp = i;
    need = 0;
    wrs  = '0;
    for (int i = 0; i < LANES; i++) begin
      wrs[i] = m_valid[i] && (i <= kp) && !m_exc[i] && (m_we[i] != 4'h0);
      if (wrs[i]) need++;
    end
    ready = (DEPTH - q.size()) >= need;
    send  = ready && (kp < LANES);
    for (int i = 0; i < LANES; i++) begin
      e_we[i*4 +: 4]    = (wrs[i] && ready) ? m_we[i] : 4'h0;
      e_addr[i*5 +: 5]  = m_dest[i];
      e_data[i*32 +: 32] = m_res[i];
    end
    e_exc = 1'b0; e_eret = 1'b0; e_pc = '0;
    if (kp < LANES) begin
      e_pc   = m_pc[kp];
      e_exc  = send && m_exc[kp];
      e_eret = send && !m_exc[kp];
    end
    m_allow = (m_valid == '0) || ready;

    chk("ws_allowin", ws_allowin, m_allow);
    chk("rf_we", rf_we, e_we);
    chk("rf_waddr", rf_waddr, e_addr);
    chk("rf_wdata", rf_wdata, e_data);
    chk("fwd_valid", fwd_valid, wrs);
    chk("send_flush", send_flush, send);
    chk("exc_valid", exc_valid, e_exc);
    chk("eret_valid", eret_valid, e_eret);
    chk("exc_pc", exc_pc, e_pc);
    chk("debug_wb_pc", debug_wb_pc, m_dbg.pc);
    chk("debug_wb_rf_wen", debug_wb_rf_wen, m_dbg.we);
    chk("debug_wb_rf_wnum", debug_wb_rf_wnum, m_dbg.num);
    chk("debug_wb_rf_wdata", debug_wb_rf_wdata, m_dbg.data);

    if (reset) begin
      model_clear();
    end else begin
      if (ready)
        for (int i = 0; i < LANES; i++)
          if (wrs[i]) q.push_back(entry_t'{m_pc[i], m_we[i], m_dest[i], m_res[i]});
      if (q.size() > 0) m_dbg = q.pop_front();
      else              m_dbg = '0;
      if (m_allow && (|ms_to_ws_valid)) begin
        m_exc  = ms_exc;
        m_eret = ms_eret;
        for (int i = 0; i < LANES; i++) begin
          m_pc[i]   = ms_pc[i*32 +: 32];
          m_res[i]  = ms_result[i*32 +: 32];
          m_we[i]   = ms_gr_we[i*4 +: 4];
          m_dest[i] = ms_dest[i*5 +: 5];
        end
      end
      if (flush)        m_valid = '0;
      else if (m_allow) m_valid = ms_to_ws_valid;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    step();
    reset = 1'b0;

    // Single lane retire, traced one cycle later.
    set_lane(0, 32'hBFC0_0000, 4'hF, 5'd5, 32'h1234, 1'b0, 1'b0);
    step();
    idle_inputs();
    chk("t1_rf_we", rf_we[3:0], 4'hF);
    step();
    chk("t1_dbg_pc", debug_wb_pc, 32'hBFC0_0000);
    chk("t1_dbg_wnum", debug_wb_rf_wnum, 5'd5);
    chk("t1_dbg_wdata", debug_wb_rf_wdata, 32'h1234);

    // Dual write, serialised in lane order.
    set_lane(0, 32'h0000_0100, 4'hF, 5'd1, 32'h11, 1'b0, 1'b0);
    set_lane(1, 32'h0000_0104, 4'hF, 5'd2, 32'h22, 1'b0, 1'b0);
    step();
    idle_inputs();
    chk("t2_rf_we", rf_we, 8'hFF);
    step();
    chk("t2_trace0_wnum", debug_wb_rf_wnum, 5'd1);
    step();
    chk("t2_trace1_wnum", debug_wb_rf_wnum, 5'd2);
    chk("t2_trace1_wdata", debug_wb_rf_wdata, 32'h22);

    // Exception in lane 0 kills lane 1.
    set_lane(0, 32'h8000_0100, 4'h0, 5'd0, 32'h0, 1'b1, 1'b0);
    set_lane(1, 32'h8000_0104, 4'hF, 5'd3, 32'h33, 1'b0, 1'b0);
    step();
    idle_inputs();
    chk("t3_send_flush", send_flush, 1'b1);
    chk("t3_exc_valid", exc_valid, 1'b1);
    chk("t3_exc_pc", exc_pc, 32'h8000_0100);
    chk("t3_rf_we", rf_we, 8'h00);
    step();
    chk("t3_no_trace", debug_wb_rf_wen, 4'h0);

    // Eret in lane 1 after a lane-0 write.
    set_lane(0, 32'h0000_0200, 4'hF, 5'd4, 32'h44, 1'b0, 1'b0);
    set_lane(1, 32'h8000_0200, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    step();
    idle_inputs();
    chk("t4_rf_we", rf_we, 8'h0F);
    chk("t4_eret_valid", eret_valid, 1'b1);
    chk("t4_exc_valid", exc_valid, 1'b0);
    chk("t4_exc_pc", exc_pc, 32'h8000_0200);
    step();
    chk("t4_trace_wnum", debug_wb_rf_wnum, 5'd4);

    // Back-to-back dual writes until the FIFO pushes back.
    k = 0;
    stall_cycles = 0;
    for (int c = 0; c < 30; c++) begin
      idle_inputs();
      set_lane(0, 32'h1000 + 32'(8 * k), 4'hF, 5'(2 * k), 32'(2 * k), 1'b0, 1'b0);
      set_lane(1, 32'h1004 + 32'(8 * k), 4'hF, 5'(2 * k + 1), 32'(2 * k + 1), 1'b0, 1'b0);
      step();
      if (m_allow) k++;
      if (!ws_allowin) stall_cycles++;
    end
    idle_inputs();
    chk("bp_stall_seen", stall_cycles > 0, 1'b1);
    repeat (12) step();

    // Reset with five entries pending.
    for (int c = 0; c < 20 && q.size() < 5; c++) begin
      idle_inputs();
      set_lane(0, 32'h2000 + 32'(8 * c), 4'hF, 5'(c), 32'(c), 1'b0, 1'b0);
      set_lane(1, 32'h2004 + 32'(8 * c), 4'h3, 5'(c + 8), 32'(c + 8), 1'b0, 1'b0);
      step();
    end
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_wen", debug_wb_rf_wen, 4'h0);
    chk("rst_allowin", ws_allowin, 1'b1);
    chk("rst_rf_we", rf_we, 8'h00);

    // Flush against an incoming bundle while the trace drains.
    set_lane(0, 32'h3000, 4'hF, 5'd10, 32'hA0, 1'b0, 1'b0);
    set_lane(1, 32'h3004, 4'hF, 5'd11, 32'hA1, 1'b0, 1'b0);
    step();
    set_lane(0, 32'h3008, 4'hF, 5'd12, 32'hA2, 1'b0, 1'b0);
    set_lane(1, 32'h300C, 4'hF, 5'd13, 32'hA3, 1'b0, 1'b0);
    step();
    idle_inputs();
    set_lane(0, 32'h3010, 4'hF, 5'd14, 32'hA4, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    idle_inputs();
    chk("fl_rf_we", rf_we, 8'h00);
    chk("fl_fwd_valid", fwd_valid, 2'b00);
    chk("fl_drain", debug_wb_rf_wen, 4'hF);
    repeat (6) step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      int n;
      idle_inputs();
      n = int'($urandom_range(0, LANES));
      for (int i = 0; i < n; i++)
        set_lane(i, $urandom, ($urandom % 4 == 0) ? 4'h0 : 4'($urandom), 5'($urandom),
                 $urandom, ($urandom % 8) == 0, ($urandom % 8) == 0);
      flush = ($urandom % 25) == 0;
      reset = ($urandom % 80) == 0;
      step();
      reset = 1'b0;
    end
    idle_inputs();
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
- Parametrised multi-lane successor to the single-issue write-back stage. It sits between the memory stage and the register file / CP0 request logic.
- Retires up to LANES in-order instructions per cycle and applies precise-exception killing across lanes.
- Serialises retired register writes through a trace FIFO onto the single-lane debug trace interface.
- Backpressures the memory stage when the trace FIFO cannot absorb a bundle.

Parameters:
LANES, 2, instructions retired per cycle; lane 0 is the oldest; legal range 1..4.
TRACE_DEPTH, 8, trace FIFO entries; must be a power of two and at least LANES.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  pipeline flush; clears stage valid
ws_allowin  out  1  stage accepts a new bundle this cycle
ms_to_ws_valid  in  LANES  per-lane valid; set bits are contiguous from lane 0
ms_pc  in  LANES*32  per-lane PC
ms_result  in  LANES*32  per-lane write-back data
ms_gr_we  in  LANES*4  per-lane byte write enables
ms_dest  in  LANES*5  per-lane destination register
ms_exc  in  LANES  per-lane exception flag
ms_eret  in  LANES  per-lane eret flag
rf_we  out  LANES*4  register file byte write enables
rf_waddr  out  LANES*5  register file write addresses
rf_wdata  out  LANES*32  register file write data
fwd_valid  out  LANES  lane holds a live result for forwarding/stall logic
send_flush  out  1  exception or eret retiring this cycle
exc_valid  out  1  retiring flush cause is an exception
eret_valid  out  1  retiring flush cause is an eret
exc_pc  out  32  PC of the flushing lane
debug_wb_pc  out  32  trace PC
debug_wb_rf_wen  out  4  trace write enable
debug_wb_rf_wnum  out  5  trace register number
debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- Stage register:
  - ws_valid[LANES] and the per-lane fields load when ws_allowin = 1.
  - ws_allowin = !(|ws_valid) || ws_ready_go.
  - Per-lane fields load only when any ms_to_ws_valid bit is set and ws_allowin = 1.
- Lane effectiveness:
  - eff[i] = ws_valid[i] && no lane j < i has ws_valid[j] && (exc[j] || eret[j]).
  - fwd_valid[i] = eff[i] && |gr_we[i] && !exc[i].
- Flush-lane selection:
  - Flush lane = lowest i with eff[i] && (exc[i] || eret[i]).
  - send_flush = ws_ready_go && flush lane exists.
  - exc_valid / eret_valid come from that lane's flags; exc has priority over eret within one lane.
  - exc_pc = that lane's PC, 0 when no flush lane.
- Writers and pushes:
  - wr[i] = eff[i] && !exc[i] && |gr_we[i].
  - need = popcount(wr).
  - ws_ready_go = (TRACE_DEPTH - count) >= need.
- Register file write:
  - rf_we[i] = gr_we[i] & {4{wr[i] && ws_ready_go}}.
  - rf_waddr / rf_wdata are pass-through of the stage register.
  - A stalled bundle causes no RF write and no flush; it retries every cycle until ready_go.
- Trace FIFO:
  - On ws_ready_go, all wr lanes are pushed in lane order ({pc, gr_we, dest, result}); up to LANES pushes per cycle.
  - Pop one entry every cycle when non-empty; the debug sink never stalls.
  - Debug outputs are registered from the FIFO head. Retire-to-trace latency is at least 1 cycle; it is exactly 1 when the FIFO was empty.
  - When the FIFO is empty, all debug outputs are 0 in that cycle.
  - Simultaneous push and pop: count' = count + need - pop. Pointers wrap modulo TRACE_DEPTH. The full condition is handled by the ready_go rule, so there is no overflow.
- flush input:
  - Clears ws_valid next cycle and has priority over a load.
  - Does not touch the trace FIFO; already-retired entries still drain.
- reset:
  - Clears ws_valid, FIFO pointers/count and debug registers.
  - All outputs read 0 after reset; ws_allowin = 1.
  - A reset mid-drain discards pending trace entries.
- Arithmetic:
  - count is $clog2(TRACE_DEPTH)+1 bits.
  - popcount is $clog2(LANES+1) bits.

Test Plan:
- Single lane: lane0 valid, pc=0xBFC00000, dest=5, gr_we=4'hF, result=0x1234 -> rf_we[0]=F same cycle; next cycle debug pc=0xBFC00000, wnum=5, wdata=0x1234.
- Dual write: lanes 0/1 write r1=0x11, r2=0x22 -> both RF writes in the same cycle; trace shows r1 then r2 on consecutive cycles.
- Precise kill: lane0 exc=1, pc=0x80000100; lane1 write r3 -> send_flush=1, exc_valid=1, exc_pc=0x80000100; rf_we all zero; no trace entry.
- Eret in lane1: lane0 writes r4, lane1 eret -> r4 written and traced; eret_valid=1, exc_pc=lane1 PC.
- Backpressure: TRACE_DEPTH=8, drive back-to-back dual-write bundles -> FIFO fills; ws_allowin drops while free slots < 2; no RF write during stall; trace is gapless and in order; no entry lost.
- Flush/reset mid-operation:
  - flush with a valid bundle -> no RF write; queued trace still drains.
  - reset with 5 entries queued -> debug_wb_rf_wen=0 next cycle; ws_allowin=1.
